// File: rtl/bram_ctrl_if.sv
// Request/response handshake and BRAM pin bundle for bram_ctrl.
// The master side is the CPU/bus plus the BRAM; the slave side is the controller.
interface bram_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_rd_en;
   logic        mem_wr_en;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             mem_rd_en, mem_wr_en, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             mem_rd_en, mem_wr_en, mem_addr, mem_wdata
   );
endinterface

// File: rtl/bram_ctrl.sv
// Single-outstanding request controller for a 1-cycle-read single-port 32-bit BRAM.
// Define MEMCTRL_BYTE_STROBE_EN to build byte-enable writes via read-modify-write.
module bram_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          DEPTH     = 16384
) (
   input logic       clk,
   input logic       rst,
   bram_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE, RD, RD_DATA, RMW_RD, RMW_MERGE, WR, RESP
   } state_t;

   localparam logic [32:0] WINDOW = 33'(DEPTH) << 2;

   state_t      state, state_nxt;
   logic [32:0] offset;
   logic        addr_err;
   logic        accept;

`ifdef MEMCTRL_BYTE_STROBE_EN
   logic [3:0]  be_q;

   function automatic logic [31:0] merge_bytes(input logic [31:0] wdata,
                                               input logic [31:0] rdata,
                                               input logic [3:0]  be);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = be[i] ? wdata[8*i +: 8] : rdata[8*i +: 8];
      end
      return res;
   endfunction
`endif

   // 33-bit subtraction so addresses below the base show up as negative, not wrapped
   assign offset   = {1'b0, bus.req_addr} - {1'b0, BASE_ADDR};
   assign addr_err = (bus.req_addr[1:0] != 2'b00) || offset[32] || (offset >= WINDOW);
   assign accept   = bus.req_valid && (state == IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (addr_err)         state_nxt = RESP;
               else if (!bus.req_we) state_nxt = RD;
`ifdef MEMCTRL_BYTE_STROBE_EN
               else if (bus.req_be == 4'hF) state_nxt = WR;
               else if (bus.req_be == 4'h0) state_nxt = RESP;
               else                         state_nxt = RMW_RD;
`else
               else                  state_nxt = WR;
`endif
            end
         end
         RD:        state_nxt = RD_DATA;
         RD_DATA:   state_nxt = RESP;
`ifdef MEMCTRL_BYTE_STROBE_EN
         RMW_RD:    state_nxt = RMW_MERGE;
         RMW_MERGE: state_nxt = WR;
`endif
         WR:        state_nxt = RESP;
         RESP:      if (bus.rsp_ready) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = (state == IDLE);
      bus.rsp_valid = (state == RESP);
      bus.mem_rd_en = (state == RD) || (state == RMW_RD);
      bus.mem_wr_en = (state == WR);
   end

   // mem_addr/mem_wdata are loaded once at acceptance and held until IDLE
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
`ifdef MEMCTRL_BYTE_STROBE_EN
         be_q          <= '0;
`endif
      end else begin
         if (accept) begin
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= addr_err;
            bus.mem_addr  <= addr_err ? 16'h0000 : offset[17:2];
            if (bus.req_we && !addr_err) bus.mem_wdata <= bus.req_wdata;
`ifdef MEMCTRL_BYTE_STROBE_EN
            be_q          <= bus.req_be;
`endif
         end
         if (state == RD_DATA) bus.rsp_rdata <= bus.mem_rdata;
`ifdef MEMCTRL_BYTE_STROBE_EN
         if (state == RMW_MERGE) bus.mem_wdata <= merge_bytes(bus.mem_wdata, bus.mem_rdata, be_q);
`endif
      end
   end

endmodule

// File: tb/tb_bram_ctrl.sv
// Directed self-checking bench for bram_ctrl with a behavioural 1-cycle BRAM.
// Byte-strobe expectations follow MEMCTRL_BYTE_STROBE_EN.
module tb_bram_ctrl;
   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam int          DEPTH = 16384;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   bram_ctrl_if bus();

   bram_ctrl #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   logic [31:0] mem [0:DEPTH-1];
   int acc_cnt = 0, rsp_cnt = 0, wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
   logic [15:0] last_wr_addr = '0;

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
   end

   always @(posedge clk) begin
      if (bus.mem_wr_en) begin
         mem[bus.mem_addr[13:0]] <= bus.mem_wdata;
         last_wr_addr <= bus.mem_addr;
         wr_cnt <= wr_cnt + 1;
      end
      if (bus.mem_rd_en) begin
         bus.mem_rdata <= mem[bus.mem_addr[13:0]];
         rd_cnt <= rd_cnt + 1;
      end
      if (bus.mem_rd_en && bus.mem_wr_en) both_cnt <= both_cnt + 1;
      if (bus.req_valid && bus.req_ready) acc_cnt <= acc_cnt + 1;
      if (bus.rsp_valid && bus.rsp_ready) rsp_cnt <= rsp_cnt + 1;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called at a negedge; waits for rsp_valid (lat counts cycles since acceptance) and consumes it.
   task automatic wait_rsp(input int start, output int lat, output logic [31:0] rdata, output logic err);
      lat = start;
      while (!bus.rsp_valid && lat < 16) begin
         @(negedge clk);
         lat++;
      end
      rdata = bus.rsp_rdata;
      err   = bus.rsp_err;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
   endtask

   task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_be    = be;
   endtask

   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output int lat, output logic [31:0] rdata,
                         output logic err);
      drive(we, addr, wdata, be);
      @(negedge clk);
      bus.req_valid = 1'b0;
      wait_rsp(1, lat, rdata, err);
   endtask

   task automatic reset_mid(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input int at_cycle);
      int w0;
      drive(1'b1, addr, wdata, be);
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (at_cycle - 1) @(negedge clk);
      w0 = wr_cnt;
      rst = 1'b0;
      #1;
      check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
      check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      check({tag, "_rd_en"},     32'(bus.mem_rd_en), 32'd0);
      check({tag, "_wr_en"},     32'(bus.mem_wr_en), 32'd0);
      check({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
      check({tag, "_mem_wdata"}, bus.mem_wdata,      32'd0);
      check({tag, "_rsp_rdata"}, bus.rsp_rdata,      32'd0);
      check({tag, "_rsp_err"},   32'(bus.rsp_err),   32'd0);
      repeat (2) begin
         @(negedge clk);
         check({tag, "_no_rsp"}, 32'(bus.rsp_valid), 32'd0);
      end
      rst = 1'b1;
      @(negedge clk);
      check({tag, "_no_write"}, 32'(wr_cnt - w0), 32'd0);
   endtask

   int          lat;
   logic [31:0] rdata;
   logic        err;
   int          a0, r0, w0, rd0;

   initial begin
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_be    = '0;
      bus.rsp_ready = 1'b0;

      // Reset values while held in reset
      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_rdata", bus.rsp_rdata,      32'd0);
      check("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
      check("rst_rd_en",     32'(bus.mem_rd_en), 32'd0);
      check("rst_wr_en",     32'(bus.mem_wr_en), 32'd0);
      check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
      check("rst_mem_wdata", bus.mem_wdata,      32'd0);
      rst = 1'b1;
      @(negedge clk);

      // Full-word write then read back
      w0 = wr_cnt;
      do_req(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, lat, rdata, err);
      check("wr_lat",       32'(lat), 32'd2);
      check("wr_err",       32'(err), 32'd0);
      check("wr_rdata",     rdata,    32'd0);
      check("wr_pulses",    32'(wr_cnt - w0), 32'd1);
      check("wr_addr",      32'(last_wr_addr), 32'd4);
      check("wr_mem",       mem[4],   32'hDEAD_BEEF);
      do_req(1'b0, BASE + 32'h10, 32'h0, 4'h0, lat, rdata, err);
      check("rd_lat",       32'(lat), 32'd3);
      check("rd_data",      rdata,    32'hDEAD_BEEF);
      check("rd_err",       32'(err), 32'd0);

      // Partial-strobe write
      do_req(1'b1, BASE + 32'h20, 32'h1122_3344, 4'hF, lat, rdata, err);
      do_req(1'b1, BASE + 32'h20, 32'hAABB_CCDD, 4'b0101, lat, rdata, err);
`ifdef MEMCTRL_BYTE_STROBE_EN
      check("rmw_lat",      32'(lat), 32'd4);
      do_req(1'b0, BASE + 32'h20, 32'h0, 4'h0, lat, rdata, err);
      check("rmw_data",     rdata,    32'h11BB_33DD);
      w0 = wr_cnt; rd0 = rd_cnt;
      do_req(1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 4'h0, lat, rdata, err);
      check("be0_lat",      32'(lat), 32'd1);
      check("be0_no_mem",   32'((wr_cnt - w0) + (rd_cnt - rd0)), 32'd0);
      do_req(1'b0, BASE + 32'h20, 32'h0, 4'h0, lat, rdata, err);
      check("be0_data",     rdata,    32'h11BB_33DD);
`else
      check("strobe_lat",   32'(lat), 32'd2);
      do_req(1'b0, BASE + 32'h20, 32'h0, 4'h0, lat, rdata, err);
      check("strobe_data",  rdata,    32'hAABB_CCDD);
      do_req(1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 4'h0, lat, rdata, err);
      check("be0_lat",      32'(lat), 32'd2);
      do_req(1'b0, BASE + 32'h20, 32'h0, 4'h0, lat, rdata, err);
      check("be0_data",     rdata,    32'hFFFF_FFFF);
`endif

      // Address errors never touch memory
      w0 = wr_cnt; rd0 = rd_cnt;
      do_req(1'b0, BASE + 32'h2, 32'h0, 4'h0, lat, rdata, err);
      check("mis_lat",   32'(lat), 32'd1);
      check("mis_err",   32'(err), 32'd1);
      check("mis_rdata", rdata,    32'd0);
      do_req(1'b0, BASE + 32'(DEPTH * 4), 32'h0, 4'h0, lat, rdata, err);
      check("oor_lat",   32'(lat), 32'd1);
      check("oor_err",   32'(err), 32'd1);
      check("oor_rdata", rdata,    32'd0);
      do_req(1'b1, BASE + 32'(DEPTH * 4), 32'h1234_5678, 4'hF, lat, rdata, err);
      check("oor_wr_err", 32'(err), 32'd1);
      do_req(1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, lat, rdata, err);
      check("top_err",   32'(err), 32'd1);
      check("err_no_mem", 32'((wr_cnt - w0) + (rd_cnt - rd0)), 32'd0);
      do_req(1'b0, BASE + 32'(DEPTH * 4 - 4), 32'h0, 4'h0, lat, rdata, err);
      check("last_err",  32'(err), 32'd0);
      check("last_lat",  32'(lat), 32'd3);

      // Backpressure on the response while a new request waits
      drive(1'b0, BASE + 32'h10, 32'h0, 4'h0);
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.rsp_valid && lat < 16) begin
         @(negedge clk);
         lat++;
      end
      check("hold_lat", 32'(lat), 32'd3);
      drive(1'b1, BASE + 32'h30, 32'h5555_AAAA, 4'hF);
      a0 = acc_cnt;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(bus.rsp_valid), 32'd1);
         check("hold_rdata", bus.rsp_rdata,      32'hDEAD_BEEF);
         check("hold_ready", 32'(bus.req_ready), 32'd0);
      end
      check("hold_no_acc", 32'(acc_cnt - a0), 32'd0);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check("rel_idle",   32'(bus.req_ready), 32'd1);
      check("rel_no_acc", 32'(acc_cnt - a0), 32'd0);
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("rel_acc",    32'(acc_cnt - a0), 32'd1);
      wait_rsp(1, lat, rdata, err);
      check("rel_wr_lat", 32'(lat), 32'd2);
      do_req(1'b0, BASE + 32'h30, 32'h0, 4'h0, lat, rdata, err);
      check("rel_wr_data", rdata, 32'h5555_AAAA);

      // Back-to-back reads with rsp_ready held high
      a0 = acc_cnt; r0 = rsp_cnt;
      bus.rsp_ready = 1'b1;
      drive(1'b0, BASE + 32'h10, 32'h0, 4'h0);
      repeat (12) @(negedge clk);
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      check("tput_acc", 32'(acc_cnt - a0), 32'd3);
      check("tput_rsp", 32'(rsp_cnt - r0), 32'd3);

      // Reset during WR drops the write
      reset_mid("rst_wr", BASE + 32'h10, 32'h1234_5678, 4'hF, 1);
      do_req(1'b0, BASE + 32'h10, 32'h0, 4'h0, lat, rdata, err);
      check("rst_wr_keep", rdata, 32'hDEAD_BEEF);
`ifdef MEMCTRL_BYTE_STROBE_EN
      reset_mid("rst_rmw", BASE + 32'h10, 32'h1234_5678, 4'b0011, 2);
      do_req(1'b0, BASE + 32'h10, 32'h0, 4'h0, lat, rdata, err);
      check("rst_rmw_keep", rdata, 32'hDEAD_BEEF);
`endif

      check("rd_wr_overlap", 32'(both_cnt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/bram_ctrl.md
# bram_ctrl

Request-side controller for the MCU's single-port 32-bit BRAM (16384 words, 1-cycle registered read, synchronous write). Accepts word requests from the CPU/bus over a valid/ready handshake, sequences the BRAM's rd_en/wr_en/addr/idata pins, captures read data and returns a response over a second valid/ready handshake. Adds address decode/range checking and optional byte-strobe writes via read-modify-write.

## Interface
- BASE_ADDR, 32'h0000_0000, byte address of BRAM word 0
- DEPTH, 16384, words in the BRAM; decoded window is DEPTH*4 bytes
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- req_be  in  4  byte enables, bit i = byte [8i+7:8i]
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  read data (0 for writes and errors)
- rsp_err  out  1  request was misaligned or out of range
- mem_rd_en  out  1  to BRAM rd_en
- mem_wr_en  out  1  to BRAM wr_en
- mem_addr  out  16  to BRAM addr, word index, upper bits zero
- mem_wdata  out  32  to BRAM idata
- mem_rdata  in  32  from BRAM odata

## Operation
- One outstanding request; the request is latched on handshake (req_valid & req_ready).
- States: IDLE, RD, RD_DATA, RMW_RD, RMW_MERGE, WR, RESP.
- IDLE: req_ready=1, all mem enables 0. On handshake: error → RESP(err); read → RD; write with be=4'hF → WR; write with be=0 → RESP (no memory access); other be → RMW_RD.
- Error: req_addr[1:0]≠0, req_addr<BASE_ADDR, or req_addr−BASE_ADDR ≥ DEPTH*4 (computed at 33 bits, no wrap). Error responses never touch memory.
- mem_addr = (latched_addr−BASE_ADDR)>>2; held stable from the acceptance edge until return to IDLE.
- RD: mem_rd_en=1 → RD_DATA. RD_DATA: mem_rdata valid; registered into rsp_rdata → RESP.
- RMW_RD: mem_rd_en=1 → RMW_MERGE. RMW_MERGE: for each byte, merged = be[i] ? wdata byte : mem_rdata byte → WR.
- WR: mem_wr_en=1 for exactly one cycle with mem_wdata → RESP.
- RESP: rsp_valid=1, rsp_rdata/rsp_err stable; on rsp_ready → IDLE. req_ready=0 in every state except IDLE.
- mem_rd_en and mem_wr_en are never both high.

## Timing
- Reset (async, rst=0): state IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; mem_rd_en=0; mem_wr_en=0; mem_addr=0; mem_wdata=0.
- Acceptance edge = cycle 0. rsp_valid first high: read cycle 3; full write cycle 2; RMW write cycle 4; error or be=0 write cycle 1.
- With rsp_ready held high, read throughput is one request per 4 cycles (RESP→IDLE costs one cycle).
- rsp_ready low: RESP holds indefinitely, outputs unchanged.
- Reset mid-operation: in-flight request dropped with no response; a write is lost unless WR already completed.
- req_* inputs are ignored outside IDLE.

## Configuration
- MEMCTRL_BYTE_STROBE_EN defined: byte-enable writes as above (RMW_RD/RMW_MERGE present, be=0 is a no-op).
- Undefined: req_be ignored; every write is a full-word write via WR (response at cycle 2); RMW states not built.

## Test plan
- Reset, then write 0xDEADBEEF to BASE_ADDR+0x10 (be=F), read it back → mem_wr_en one pulse with mem_addr=4; read rsp_rdata=0xDEADBEEF at cycle 3, rsp_err=0.
- With macro: write 0x11223344 (be=F), then 0xAABBCCDD with be=4'b0101 to the same word → read returns 0x11BB33DD; response timing cycle 4.
- req_addr=BASE_ADDR+0x2 and BASE_ADDR+DEPTH*4 → rsp_err=1, rsp_rdata=0, at cycle 1, no mem enable ever asserted.
- Hold rsp_ready=0 for 5 cycles after a read → rsp_valid and rsp_rdata stable, req_ready=0 throughout; request accepted the cycle after rsp_ready rises.
- Assert rst during RMW_MERGE → all outputs at reset values immediately, no rsp_valid, no mem_wr_en; target word unchanged on readback.
